dac_ltc2624_tx: RTL and testbench

//  SPI write master for the Spartan-3E on-board LTC2624 quad 12-bit DAC; the output-side counterpart of the ADC/preamp capture path.

---
 rtl/dac_ltc2624_tx_if.sv | 14 +
 rtl/dac_ltc2624_tx.sv | 140 ++++++++++++++
 tb/tb_dac_ltc2624_tx.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_ltc2624_tx_if.sv
// Request/response side of the LTC2624 write master: user logic drives master,
// the SPI engine sits on slave.
interface dac_ltc2624_tx_if;
    logic        start;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic        busy;
    logic        done;
    logic [31:0] echo;

    modport master (output start, cmd, addr, data, input busy, done, echo);
    modport slave  (input start, cmd, addr, data, output busy, done, echo);
endinterface

// File: rtl/dac_ltc2624_tx.sv
// SPI write master for the LTC2624 quad DAC: one 32-bit frame per accepted request,
// MSB first on mosi/sck under dac_cs, with the DAC's SDO echo captured in parallel.
module dac_ltc2624_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic            clock_in,
    input  logic            rst_n,
    dac_ltc2624_tx_if.slave bus,
    input  logic            miso,
    output logic            dac_cs,
    output logic            mosi,
    output logic            sck,
    output logic            dac_clr
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state, state_d;
    logic [7:0]  div_cnt, div_d;
    logic [4:0]  bit_cnt, bit_d;
    logic        cs_d, sck_d, mosi_d, busy_d, done_d;
    logic        load, shift_tx, sample_rx, load_echo;
    logic [31:0] frame;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic        phase_end;

    assign frame     = {8'h00, bus.cmd, bus.addr, bus.data, 4'h0};
    assign phase_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clock_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            dac_cs   <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            dac_clr  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.echo <= '0;
        end else begin
            state    <= state_d;
            div_cnt  <= div_d;
            bit_cnt  <= bit_d;
            dac_cs   <= cs_d;
            sck      <= sck_d;
            mosi     <= mosi_d;
            dac_clr  <= 1'b1;
            bus.busy <= busy_d;
            bus.done <= done_d;
            if (load_echo) bus.echo <= rx_sr;
        end
    end

    // Shift registers carry no reset: they are always fully reloaded before use.
    always_ff @(posedge clock_in) begin
        if (load)
            tx_sr <= {frame[30:0], 1'b0};
        else if (shift_tx)
            tx_sr <= {tx_sr[30:0], 1'b0};
        if (sample_rx)
            rx_sr <= {rx_sr[30:0], miso};
    end

    always_comb begin
        state_d   = state;
        div_d     = div_cnt + 8'd1;
        bit_d     = bit_cnt;
        cs_d      = dac_cs;
        sck_d     = sck;
        mosi_d    = mosi;
        busy_d    = bus.busy;
        done_d    = 1'b0;
        load      = 1'b0;
        shift_tx  = 1'b0;
        sample_rx = 1'b0;
        load_echo = 1'b0;
        case (state)
            IDLE: begin
                div_d = '0;
                if (bus.start) begin
                    load    = 1'b1;
                    cs_d    = 1'b0;
                    mosi_d  = frame[31];
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                // Echo sampled on the clock that drops sck; the next mosi bit leaves on the same edge.
                if (phase_end) begin
                    div_d     = '0;
                    sck_d     = 1'b0;
                    sample_rx = 1'b1;
                    shift_tx  = 1'b1;
                    mosi_d    = tx_sr[31];
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    div_d = '0;
                    bit_d = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        cs_d      = 1'b1;
                        done_d    = 1'b1;
                        load_echo = 1'b1;
                        state_d   = GAP;
                    end else begin
                        sck_d   = 1'b1;
                        state_d = SHIFT_HI;
                    end
                end
            end
            GAP: begin
                if (div_cnt == GAP_LAST) begin
                    div_d   = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dac_ltc2624_tx.sv
// Bench for dac_ltc2624_tx: a timing-arithmetic reference checked every cycle on two
// instances (CLK_DIV=2/CS_GAP=2 and CLK_DIV=1/CS_GAP=3), plus directed literal checks.
module tb_dac_ltc2624_tx;

    localparam int DIV0 = 2;
    localparam int GAP0 = 2;
    localparam int DIV1 = 1;
    localparam int GAP1 = 3;
    localparam int BIG  = 1000000;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] start_v;
    logic [3:0]  cmd_v  [2];
    logic [3:0]  addr_v [2];
    logic [11:0] data_v [2];
    logic [31:0] mword  [2];
    logic miso0, miso1;
    logic [1:0] cs_o, sck_o, mosi_o, clr_o, busy_o, done_o;

    dac_ltc2624_tx_if bus0 ();
    dac_ltc2624_tx_if bus1 ();

    assign bus0.start = start_v[0];
    assign bus0.cmd   = cmd_v[0];
    assign bus0.addr  = addr_v[0];
    assign bus0.data  = data_v[0];
    assign bus1.start = start_v[1];
    assign bus1.cmd   = cmd_v[1];
    assign bus1.addr  = addr_v[1];
    assign bus1.data  = data_v[1];
    assign busy_o     = {bus1.busy, bus0.busy};
    assign done_o     = {bus1.done, bus0.done};

    dac_ltc2624_tx #(.CLK_DIV(DIV0), .CS_GAP(GAP0)) u_dut0 (
        .clock_in(clk), .rst_n(rst_n), .bus(bus0), .miso(miso0),
        .dac_cs(cs_o[0]), .mosi(mosi_o[0]), .sck(sck_o[0]), .dac_clr(clr_o[0])
    );

    dac_ltc2624_tx #(.CLK_DIV(DIV1), .CS_GAP(GAP1)) u_dut1 (
        .clock_in(clk), .rst_n(rst_n), .bus(bus1), .miso(miso1),
        .dac_cs(cs_o[1]), .mosi(mosi_o[1]), .sck(sck_o[1]), .dac_clr(clr_o[1])
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference: n = clocks since the accepting edge; every output is a function of n.
    int          n       [2] = '{BIG, BIG};
    logic [31:0] mframe  [2] = '{32'h0, 32'h0};
    logic [31:0] mecho   [2] = '{32'h0, 32'h0};
    logic [31:0] mecho_nx[2] = '{32'h0, 32'h0};
    logic        clr_exp = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                clr_exp = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    n[i] = BIG; mframe[i] = '0; mecho[i] = '0;
                end
            end else begin
                clr_exp = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    int d, g, l;
                    d = (i == 0) ? DIV0 : DIV1;
                    g = (i == 0) ? GAP0 : GAP1;
                    l = 65 * d;
                    if (n[i] >= l + g) begin
                        if (start_v[i]) begin
                            n[i]        = 0;
                            mframe[i]   = {8'h00, cmd_v[i], addr_v[i], data_v[i], 4'h0};
                            mecho_nx[i] = mword[i];
                        end
                    end else begin
                        n[i]++;
                        if (n[i] == l) mecho[i] = mecho_nx[i];
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                for (int i = 0; i < 2; i++) begin
                    int d, g, l, nn, k, pr, b;
                    logic e_cs, e_sck, e_mosi, e_busy, e_done;
                    logic [31:0] act_echo;
                    d = (i == 0) ? DIV0 : DIV1;
                    g = (i == 0) ? GAP0 : GAP1;
                    l = 65 * d;
                    nn = n[i];
                    e_cs = (nn < l) ? 1'b0 : 1'b1;
                    e_sck = 1'b0;
                    e_mosi = 1'b0;
                    if (nn < d) begin
                        e_mosi = mframe[i][31];
                    end else if (nn < l) begin
                        k  = (nn - d) / d;
                        pr = k / 2;
                        if (k % 2 == 0) begin
                            e_sck  = 1'b1;
                            e_mosi = mframe[i][31 - pr];
                        end else begin
                            b = 30 - pr;
                            e_mosi = (b >= 0) ? mframe[i][b] : 1'b0;
                        end
                    end
                    e_done = (nn == l);
                    e_busy = (nn < l + g);
                    act_echo = (i == 0) ? bus0.echo : bus1.echo;
                    chk($sformatf("cs%0d", i),   cs_o[i],   e_cs);
                    chk($sformatf("sck%0d", i),  sck_o[i],  e_sck);
                    chk($sformatf("mosi%0d", i), mosi_o[i], e_mosi);
                    chk($sformatf("busy%0d", i), busy_o[i], e_busy);
                    chk($sformatf("done%0d", i), done_o[i], e_done);
                    chk($sformatf("echo%0d", i), act_echo,  mecho[i]);
                    chk($sformatf("clr%0d", i),  clr_o[i],  clr_exp);
                end
            end
        end
    end

    // Bus-side observers: mosi captured on rising sck, miso changed on falling sck.
    logic [31:0] cap0, cap1;
    int rises0, rises1, cslow0, cslow1, cshigh0, last_gap0, dn0, dn1;
    int mp0, mp1, cyc, last_rise1, per_bad1;

    initial forever begin @(posedge clk); cyc++; end
    initial forever begin
        @(negedge cs_o[0]);
        cap0 = '0; rises0 = 0; cslow0 = 0; last_gap0 = cshigh0; mp0 = 31; miso0 = mword[0][31];
    end
    initial forever begin
        @(negedge cs_o[1]);
        cap1 = '0; rises1 = 0; cslow1 = 0; per_bad1 = 0; mp1 = 31; miso1 = mword[1][31];
    end
    initial forever begin @(posedge cs_o[0]); cshigh0 = 0; end
    initial forever begin
        @(negedge clk);
        if (!cs_o[0]) cslow0++; else cshigh0++;
        if (!cs_o[1]) cslow1++;
    end
    initial forever begin @(posedge sck_o[0]); cap0 = {cap0[30:0], mosi_o[0]}; rises0++; end
    initial forever begin
        @(posedge sck_o[1]);
        if (rises1 > 0 && cyc - last_rise1 != 2) per_bad1++;
        last_rise1 = cyc;
        cap1 = {cap1[30:0], mosi_o[1]};
        rises1++;
    end
    initial forever begin @(negedge sck_o[0]); if (mp0 > 0) mp0--; miso0 = mword[0][mp0]; end
    initial forever begin @(negedge sck_o[1]); if (mp1 > 0) mp1--; miso1 = mword[1][mp1]; end
    initial forever begin @(posedge done_o[0]); dn0++; end
    initial forever begin @(posedge done_o[1]); dn1++; end

    task automatic set_req(input int i, input logic [3:0] c, input logic [3:0] a,
                           input logic [11:0] d, input logic [31:0] w);
        cmd_v[i] = c; addr_v[i] = a; data_v[i] = d; mword[i] = w;
    endtask

    task automatic pulse(input int i);
        @(negedge clk);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input string nm);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (done_o[i]) return;
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int i, input string nm);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!busy_o[i]) return;
        end
        chk({nm, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=stalled want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start_v = 2'b00;
        miso0 = 1'b0; miso1 = 1'b0;
        cyc = 0; dn0 = 0; dn1 = 0; cshigh0 = 0; last_gap0 = 0;
        rises0 = 0; rises1 = 0; cslow0 = 0; cslow1 = 0; per_bad1 = 0; last_rise1 = 0;
        cap0 = '0; cap1 = '0; mp0 = 31; mp1 = 31;
        set_req(0, 4'h0, 4'h0, 12'h000, 32'h0);
        set_req(1, 4'h0, 4'h0, 12'h000, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mon_on = 1'b1;

        chk("rst_cs",   cs_o[0],   1'b1);
        chk("rst_sck",  sck_o[0],  1'b0);
        chk("rst_mosi", mosi_o[0], 1'b0);
        chk("rst_clr",  clr_o[0],  1'b0);
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_echo", bus0.echo, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_clr",  clr_o[0],  1'b1);
        chk("rel_cs",   cs_o[0],   1'b1);
        chk("rel_busy", busy_o[0], 1'b0);

        // Plain write with echo
        set_req(0, 4'h3, 4'hF, 12'hABC, 32'hDEADBEEF);
        dn0 = 0;
        pulse(0);
        wait_done(0, "t1");
        chk("t1_mosi_word", cap0,      32'h003FABC0);
        chk("t1_rises",     rises0,    32);
        chk("t1_cs_low",    cslow0,    130);
        chk("t1_echo",      bus0.echo, 32'hDEADBEEF);
        wait_idle(0, "t1");
        chk("t1_done_count", dn0, 1);

        // Start during a frame is dropped
        set_req(0, 4'h2, 4'h1, 12'h5A5, 32'h12345678);
        dn0 = 0;
        pulse(0);
        repeat (20) @(negedge clk);
        cmd_v[0] = 4'h3; addr_v[0] = 4'h7; data_v[0] = 12'hFFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, "t2");
        chk("t2_mosi_word", cap0,      32'h00215A50);
        chk("t2_echo",      bus0.echo, 32'h12345678);
        wait_idle(0, "t2");
        repeat (10) @(negedge clk);
        chk("t2_done_count", dn0, 1);

        // start held high: back-to-back frames
        set_req(0, 4'h3, 4'h2, 12'h123, 32'hCAFE0001);
        dn0 = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        wait_done(0, "t3a");
        wait_done(0, "t3b");
        start_v[0] = 1'b0;
        chk("t3_cs_gap",    last_gap0, GAP0 + 1);
        chk("t3_mosi_word", cap0,      32'h00321230);
        chk("t3_echo",      bus0.echo, 32'hCAFE0001);
        chk("t3_done_count", dn0, 2);
        wait_idle(0, "t3");
        repeat (5) @(negedge clk);

        // Reset mid-frame after the 10th sck rise
        set_req(0, 4'h3, 4'h4, 12'h800, 32'h0F0F0F0F);
        dn0 = 0;
        pulse(0);
        for (int c = 0; c < 300; c++) begin
            if (rises0 == 10) break;
            @(negedge clk);
        end
        chk("t4_rise10", rises0, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_ab_cs",   cs_o[0],   1'b1);
        chk("t4_ab_sck",  sck_o[0],  1'b0);
        chk("t4_ab_busy", busy_o[0], 1'b0);
        chk("t4_ab_echo", bus0.echo, 32'h0);
        chk("t4_ab_clr",  clr_o[0],  1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_no_done", dn0, 0);
        pulse(0);
        wait_done(0, "t4");
        chk("t4_mosi_word", cap0,      32'h00348000);
        chk("t4_rises",     rises0,    32);
        chk("t4_cs_low",    cslow0,    130);
        chk("t4_echo",      bus0.echo, 32'h0F0F0F0F);
        wait_idle(0, "t4");

        // Max rate instance
        set_req(1, 4'h3, 4'h0, 12'h001, 32'hA5A50F0F);
        dn1 = 0;
        pulse(1);
        wait_done(1, "t5");
        chk("t5_mosi_word", cap1,      32'h00300010);
        chk("t5_rises",     rises1,    32);
        chk("t5_cs_low",    cslow1,    65);
        chk("t5_sck_period", per_bad1, 0);
        chk("t5_echo",      bus1.echo, 32'hA5A50F0F);
        wait_idle(1, "t5");
        chk("t5_done_count", dn1, 1);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
